// File: rtl/op_lut_src_port_parser_pkg.sv
// Shared definitions for the output-port-lookup source-port parser:
// FSM state and CPU-mapping encodings, result-entry width and log2 helper.
// Also supplies defaults for the IOQ header macros when the including
// build does not define them.

`ifndef IO_QUEUE_STAGE_NUM
`define IO_QUEUE_STAGE_NUM 8'hff
`endif

`ifndef IOQ_SRC_PORT_POS
`define IOQ_SRC_PORT_POS 16
`endif

package op_lut_src_port_parser_pkg;

    // Header-snooping FSM states
    typedef enum logic {
        PARSE_HDRS = 1'b0,
        WAIT_EOP   = 1'b1
    } state_e;

    // CPU/MAC port pairing schemes
    typedef enum logic {
        CPU_MAP_INTERLEAVED = 1'b0,
        CPU_MAP_SPLIT       = 1'b1
    } cpu_map_e;

    // Width of the IOQ source-port field inside the module header
    localparam int unsigned SRC_PORT_FIELD_WIDTH = 16;

    // Ceiling log2, with log2(1) = 0
    function automatic int unsigned log2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Result entry layout, MSB first:
    //   {src_port_err, is_from_cpu, to_cpu[NQ], from_cpu[NQ], port_num[NQW]}
    function automatic int unsigned entry_width(input int unsigned num_queues,
                                                input int unsigned num_queues_width);
        return 2 + 2 * num_queues + num_queues_width;
    endfunction

endpackage

// File: rtl/op_lut_src_port_parser_if.sv
// Bus between the module-header stream / lookup process block and the
// source-port parser. The parser is the slave side.

interface op_lut_src_port_parser_if #(
    parameter int unsigned DATA_WIDTH       = 64,
    parameter int unsigned CTRL_WIDTH       = DATA_WIDTH / 8,
    parameter int unsigned NUM_QUEUES       = 8,
    parameter int unsigned NUM_QUEUES_WIDTH = op_lut_src_port_parser_pkg::log2(NUM_QUEUES)
);

    logic [DATA_WIDTH-1:0]       in_data;
    logic [CTRL_WIDTH-1:0]       in_ctrl;
    logic                        in_wr;
    logic                        in_rdy;
    logic                        rd_hdr_parser;
    logic                        is_from_cpu_vld;
    logic                        is_from_cpu;
    logic [NUM_QUEUES-1:0]       to_cpu_output_port;
    logic [NUM_QUEUES-1:0]       from_cpu_output_port;
    logic [NUM_QUEUES_WIDTH-1:0] input_port_num;
    logic                        src_port_err;
    logic                        overflow_err;

    modport slave (
        input  in_data, in_ctrl, in_wr, rd_hdr_parser,
        output in_rdy, is_from_cpu_vld, is_from_cpu, to_cpu_output_port,
               from_cpu_output_port, input_port_num, src_port_err, overflow_err
    );

    modport master (
        output in_data, in_ctrl, in_wr, rd_hdr_parser,
        input  in_rdy, is_from_cpu_vld, is_from_cpu, to_cpu_output_port,
               from_cpu_output_port, input_port_num, src_port_err, overflow_err
    );

endinterface

// File: rtl/fallthrough_small_fifo.sv
// Small fall-through FIFO: the head entry is visible on dout while the FIFO
// is non-empty; dout reads zero when empty. A write on a full FIFO succeeds
// only when a read is accepted in the same cycle. Active-low async reset.

module fallthrough_small_fifo #(
    parameter int unsigned WIDTH          = 72,
    parameter int unsigned MAX_DEPTH_BITS = 3
) (
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             nearly_full,
    output logic             empty,
    input  logic             clk,
    input  logic             reset
);

    localparam int unsigned                 DEPTH       = 2 ** MAX_DEPTH_BITS;
    localparam logic [MAX_DEPTH_BITS:0]     FULL_CNT    = (MAX_DEPTH_BITS + 1)'(DEPTH);
    localparam logic [MAX_DEPTH_BITS:0]     NEARLY_CNT  = FULL_CNT - 1'b1;

    logic [WIDTH-1:0]          mem [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr;
    logic [MAX_DEPTH_BITS-1:0] rd_ptr;
    logic [MAX_DEPTH_BITS:0]   depth;
    logic                      do_wr;
    logic                      do_rd;

    assign empty       = (depth == '0);
    assign full        = (depth == FULL_CNT);
    assign nearly_full = (depth >= NEARLY_CNT);
    assign do_rd       = rd_en && !empty;
    assign do_wr       = wr_en && (!full || do_rd);
    assign dout        = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy tracking
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            depth  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   depth <= depth + 1'b1;
                2'b01:   depth <= depth - 1'b1;
                default: depth <= depth;
            endcase
        end
    end

    // Storage array, written only on accepted pushes
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/op_lut_src_port_decode.sv
// Combinational decode of a 16-bit IOQ source port into the lookup result
// fields. CPU_MAP_MODE selects interleaved (odd = CPU, CPU = MAC+1) or
// split (upper half = CPU, CPU = MAC + NUM_QUEUES/2) port pairing.

module op_lut_src_port_decode
    import op_lut_src_port_parser_pkg::*;
#(
    parameter int unsigned NUM_QUEUES       = 8,
    parameter int unsigned NUM_QUEUES_WIDTH = log2(NUM_QUEUES),
    parameter int          CPU_MAP_MODE     = 0
) (
    input  logic [SRC_PORT_FIELD_WIDTH-1:0] src_port,
    output logic                            src_port_err,
    output logic                            is_from_cpu,
    output logic [NUM_QUEUES-1:0]           to_cpu_output_port,
    output logic [NUM_QUEUES-1:0]           from_cpu_output_port,
    output logic [NUM_QUEUES_WIDTH-1:0]     input_port_num
);

    localparam bit                    SPLIT  = (CPU_MAP_MODE == int'(CPU_MAP_SPLIT));
    localparam logic [15:0]           NUM_Q  = 16'(NUM_QUEUES);
    localparam logic [15:0]           HALF_Q = 16'(NUM_QUEUES / 2);
    localparam logic [NUM_QUEUES-1:0] ONE    = NUM_QUEUES'(1);

    logic        in_range;
    logic        is_cpu;
    logic [15:0] to_idx;
    logic [15:0] from_idx;

    // Classify the port and form its paired CPU/MAC one-hot vectors
    always_comb begin
        in_range = (src_port < NUM_Q);
        if (SPLIT) begin
            is_cpu   = (src_port >= HALF_Q);
            to_idx   = src_port + HALF_Q;
            from_idx = src_port - HALF_Q;
        end else begin
            is_cpu   = src_port[0];
            to_idx   = src_port + 16'd1;
            from_idx = src_port - 16'd1;
        end

        src_port_err         = !in_range;
        is_from_cpu          = in_range && is_cpu;
        to_cpu_output_port   = (in_range && !is_cpu) ? (ONE << to_idx)   : '0;
        from_cpu_output_port = (in_range &&  is_cpu) ? (ONE << from_idx) : '0;
        input_port_num       = src_port[NUM_QUEUES_WIDTH-1:0];
    end

endmodule

// File: rtl/op_lut_src_port_parser.sv
// Output-port-lookup source-port parser. Snoops the module-header stream,
// decodes the IOQ source port of each packet (or a default error entry when
// the packet carries no IOQ header) and buffers one result per packet in a
// fall-through FIFO for the lookup process block.
// Build option: define OP_LUT_SRC_PORT_STATS_EN to add saturating 32-bit
// counters num_from_cpu, num_from_mac and num_hdr_err.

module op_lut_src_port_parser
    import op_lut_src_port_parser_pkg::*;
#(
    parameter int unsigned DATA_WIDTH       = 64,
    parameter int unsigned CTRL_WIDTH       = DATA_WIDTH / 8,
    parameter int unsigned NUM_QUEUES       = 8,
    parameter int unsigned NUM_QUEUES_WIDTH = log2(NUM_QUEUES),
    parameter int unsigned FIFO_DEPTH_BITS  = 2,
    parameter int          CPU_MAP_MODE     = 0,
    parameter logic [CTRL_WIDTH-1:0] IO_QUEUE_STAGE_NUM = CTRL_WIDTH'(`IO_QUEUE_STAGE_NUM),
    parameter int unsigned SRC_PORT_POS     = `IOQ_SRC_PORT_POS
) (
    input  logic clk,
    input  logic reset,
    op_lut_src_port_parser_if.slave bus
`ifdef OP_LUT_SRC_PORT_STATS_EN
    ,
    output logic [31:0] num_from_cpu,
    output logic [31:0] num_from_mac,
    output logic [31:0] num_hdr_err
`endif
);

    localparam int unsigned ENTRY_WIDTH = entry_width(NUM_QUEUES, NUM_QUEUES_WIDTH);
    // Keep the source-port slice inside the data bus
    localparam int unsigned FIELD_POS =
        (SRC_PORT_POS + SRC_PORT_FIELD_WIDTH <= DATA_WIDTH) ? SRC_PORT_POS
                                                             : DATA_WIDTH - SRC_PORT_FIELD_WIDTH;

    typedef struct packed {
        logic                        src_port_err;
        logic                        is_from_cpu;
        logic [NUM_QUEUES-1:0]       to_cpu;
        logic [NUM_QUEUES-1:0]       from_cpu;
        logic [NUM_QUEUES_WIDTH-1:0] port_num;
    } entry_t;

    localparam entry_t DEFAULT_ENTRY = '{src_port_err: 1'b1, default: '0};

    state_e                          state;
    logic                            hdr_seen;
    logic                            is_ioq_hdr;
    logic                            is_data;
    logic                            is_eop;
    logic                            push;
    entry_t                          push_entry;
    entry_t                          dec_entry;
    entry_t                          head;
    logic [ENTRY_WIDTH-1:0]          fifo_dout;
    logic                            fifo_full;
    logic                            fifo_nearly_full;
    logic                            fifo_empty;
    logic                            pop;
    logic                            push_ok;
    logic                            overflow_q;

    logic                            dec_err;
    logic                            dec_cpu;
    logic [NUM_QUEUES-1:0]           dec_to;
    logic [NUM_QUEUES-1:0]           dec_from;
    logic [NUM_QUEUES_WIDTH-1:0]     dec_port;

    assign is_ioq_hdr = bus.in_wr && (bus.in_ctrl == IO_QUEUE_STAGE_NUM);
    assign is_data    = bus.in_wr && (bus.in_ctrl == '0);
    assign is_eop     = bus.in_wr && (bus.in_ctrl != '0);

    op_lut_src_port_decode #(
        .NUM_QUEUES       (NUM_QUEUES),
        .NUM_QUEUES_WIDTH (NUM_QUEUES_WIDTH),
        .CPU_MAP_MODE     (CPU_MAP_MODE)
    ) u_decode (
        .src_port             (bus.in_data[FIELD_POS +: SRC_PORT_FIELD_WIDTH]),
        .src_port_err         (dec_err),
        .is_from_cpu          (dec_cpu),
        .to_cpu_output_port   (dec_to),
        .from_cpu_output_port (dec_from),
        .input_port_num       (dec_port)
    );

    assign dec_entry = '{src_port_err: dec_err, is_from_cpu: dec_cpu, to_cpu: dec_to,
                         from_cpu: dec_from, port_num: dec_port};

    // Push on the first IOQ header, or a default entry on the first data word
    // of a packet that never showed one
    always_comb begin
        push       = 1'b0;
        push_entry = dec_entry;
        if (state == PARSE_HDRS && !hdr_seen) begin
            if (is_ioq_hdr) begin
                push = 1'b1;
            end else if (is_data) begin
                push       = 1'b1;
                push_entry = DEFAULT_ENTRY;
            end
        end
    end

    // Packet framing: header phase until the first data word, then wait for EOP
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= PARSE_HDRS;
            hdr_seen <= 1'b0;
        end else begin
            case (state)
                PARSE_HDRS: begin
                    if (is_ioq_hdr) begin
                        hdr_seen <= 1'b1;
                    end
                    if (is_data) begin
                        state <= WAIT_EOP;
                    end
                end
                WAIT_EOP: begin
                    if (is_eop) begin
                        state    <= PARSE_HDRS;
                        hdr_seen <= 1'b0;
                    end
                end
                default: begin
                    state    <= PARSE_HDRS;
                    hdr_seen <= 1'b0;
                end
            endcase
        end
    end

    fallthrough_small_fifo #(
        .WIDTH          (ENTRY_WIDTH),
        .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_result_fifo (
        .din         (push_entry),
        .wr_en       (push),
        .rd_en       (bus.rd_hdr_parser),
        .dout        (fifo_dout),
        .full        (fifo_full),
        .nearly_full (fifo_nearly_full),
        .empty       (fifo_empty),
        .clk         (clk),
        .reset       (reset)
    );

    assign pop     = bus.rd_hdr_parser && !fifo_empty;
    assign push_ok = push && (!fifo_full || pop);
    assign head    = entry_t'(fifo_dout);

    // One-cycle pulse when a result is dropped on a full FIFO
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= push && !push_ok;
        end
    end

`ifdef OP_LUT_SRC_PORT_STATS_EN
    // Saturating per-type counts of accepted results
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            num_from_cpu <= '0;
            num_from_mac <= '0;
            num_hdr_err  <= '0;
        end else if (push_ok) begin
            if (push_entry.src_port_err) begin
                if (num_hdr_err != '1) begin
                    num_hdr_err <= num_hdr_err + 32'd1;
                end
            end else if (push_entry.is_from_cpu) begin
                if (num_from_cpu != '1) begin
                    num_from_cpu <= num_from_cpu + 32'd1;
                end
            end else begin
                if (num_from_mac != '1) begin
                    num_from_mac <= num_from_mac + 32'd1;
                end
            end
        end
    end
`endif

    assign bus.in_rdy               = !fifo_nearly_full;
    assign bus.is_from_cpu_vld      = !fifo_empty;
    assign bus.is_from_cpu          = head.is_from_cpu;
    assign bus.to_cpu_output_port   = head.to_cpu;
    assign bus.from_cpu_output_port = head.from_cpu;
    assign bus.input_port_num       = head.port_num;
    assign bus.src_port_err         = head.src_port_err;
    assign bus.overflow_err         = overflow_q;

endmodule
